// File: rtl/stat_pkt_pkg.sv
// Shared constants for the per-flow packet byte statistics block.
package stat_pkt_pkg;

    // Default number of flow-index bits; the block tracks 2**A_WIDTH flows.
    localparam int A_WIDTH_DEF = 3;

    // Default byte-counter / read-data width.
    localparam int D_WIDTH_DEF = 32;

    // Legal counter width range; the lower bound keeps one maximum-size
    // packet representable in a counter.
    localparam int D_WIDTH_MIN = 16;
    localparam int D_WIDTH_MAX = 64;

    // Width of the incoming packet-size field, in bytes.
    localparam int PKT_SIZE_W = 16;

endpackage

// File: rtl/stat_pkt_if.sv
// Packet-report and counter-read bus of the statistics block.
// master = the agent reporting packets and issuing reads; slave = stat_pkt.
interface stat_pkt_if
    import stat_pkt_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
);

    // Packet report channel
    logic [A_WIDTH-1:0]    rx_flow_num_i;
    logic [PKT_SIZE_W-1:0] pkt_size_i;
    logic                  pkt_size_ena_i;

    // Read request channel
    logic                  rd_stb_i;
    logic [A_WIDTH-1:0]    rd_flow_num_i;

    // Read response channel
    logic [D_WIDTH-1:0]    rd_data_o;
    logic                  rd_data_val_o;

    modport master (
        output rx_flow_num_i,
        output pkt_size_i,
        output pkt_size_ena_i,
        output rd_stb_i,
        output rd_flow_num_i,
        input  rd_data_o,
        input  rd_data_val_o
    );

    modport slave (
        input  rx_flow_num_i,
        input  pkt_size_i,
        input  pkt_size_ena_i,
        input  rd_stb_i,
        input  rd_flow_num_i,
        output rd_data_o,
        output rd_data_val_o
    );

endinterface

// File: rtl/stat_pkt.sv
// Per-flow byte counters with clear-on-read access.
// Each flow owns a D_WIDTH wrapping counter. A packet report adds its size
// to the addressed counter; a read returns the addressed counter one cycle
// later and zeroes it on the same edge. When a read and a packet hit the
// same flow together, the read returns the old count and the counter
// restarts at the new packet's size, so no byte is lost or counted twice.
module stat_pkt
    import stat_pkt_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    stat_pkt_if.slave     bus
);

    localparam int N = 2 ** A_WIDTH;

    typedef logic [D_WIDTH-1:0] cnt_t;

    // Counter storage and its next-state image
    cnt_t r_cnt      [N];
    cnt_t w_cnt_next [N];

    // Read response register
    cnt_t r_rd_data_p1;
    logic r_rd_vld_p1;

    // Modulo-2**D_WIDTH accumulate of a zero-extended packet size.
    function automatic cnt_t add_wrap(input cnt_t acc, input logic [PKT_SIZE_W-1:0] size);
        return acc + cnt_t'(size);
    endfunction

    // Next counter values: clear on read first, then add any packet, so a
    // same-flow collision leaves exactly the new packet size in the counter.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (bus.rd_stb_i && (bus.rd_flow_num_i == A_WIDTH'(i))) begin
                w_cnt_next[i] = '0;
            end
            if (bus.pkt_size_ena_i && (bus.rx_flow_num_i == A_WIDTH'(i))) begin
                w_cnt_next[i] = add_wrap(w_cnt_next[i], bus.pkt_size_i);
            end
        end
    end

    // ---- stage p0 -> p1: counter update and read capture ----
    // Reset wipes every counter and any in-flight response; strobes seen
    // during reset are discarded.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
            r_rd_data_p1 <= '0;
            r_rd_vld_p1  <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            r_rd_vld_p1 <= bus.rd_stb_i;
            if (bus.rd_stb_i) begin
                r_rd_data_p1 <= r_cnt[bus.rd_flow_num_i];
            end
        end
    end

    assign bus.rd_data_o     = r_rd_data_p1;
    assign bus.rd_data_val_o = r_rd_vld_p1;

endmodule

// File: tb/tb_stat_pkt.sv
// Directed and model-checked bench for stat_pkt (8 flows, 20-bit counters).
module tb_stat_pkt;

    localparam int AW = 3;
    localparam int DW = 20;
    localparam int NF = 8;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_err    = 0;

    logic [DW-1:0] model [NF];

    stat_pkt_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

    stat_pkt #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then wait until just after the edge.
    task automatic step(input logic pe, input int pf, input int ps, input logic rs, input int rf);
        bus.pkt_size_ena_i = pe;
        bus.rx_flow_num_i  = AW'(pf);
        bus.pkt_size_i     = 16'(ps);
        bus.rd_stb_i       = rs;
        bus.rd_flow_num_i  = AW'(rf);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic pkt(input int pf, input int ps);
        step(1'b1, pf, ps, 1'b0, 0);
    endtask

    task automatic rd_chk(input string tag, input int rf, input logic [DW-1:0] exp);
        step(1'b0, 0, 0, 1'b1, rf);
        chk({tag, "_vld"}, 64'(bus.rd_data_val_o), 64'd1);
        chk({tag, "_data"}, 64'(bus.rd_data_o), 64'(exp));
    endtask

    initial begin
        logic          pe;
        logic          rs;
        int            pf;
        int            ps;
        int            rf;
        logic [DW-1:0] exp_rd;

        // Reset with live strobes: they must be ignored.
        rst_n = 1'b0;
        step(1'b1, 0, 77, 1'b1, 0);
        step(1'b1, 0, 77, 1'b1, 0);
        chk("rst_vld", 64'(bus.rd_data_val_o), 64'd0);
        chk("rst_data", 64'(bus.rd_data_o), 64'd0);

        // First edge with reset released honours the read.
        rst_n = 1'b1;
        rd_chk("rd5_after_rst", 5, 20'd0);
        rd_chk("rd0_after_rst", 0, 20'd0);
        idle();
        chk("idle_vld", 64'(bus.rd_data_val_o), 64'd0);

        // Accumulation then clear-on-read, back-to-back.
        pkt(2, 100);
        pkt(2, 200);
        pkt(2, 300);
        rd_chk("flow2_sum", 2, 20'd600);
        rd_chk("flow2_cleared", 2, 20'd0);

        // Same-flow packet and read collision.
        pkt(3, 10);
        step(1'b1, 3, 50, 1'b1, 3);
        chk("coll_vld", 64'(bus.rd_data_val_o), 64'd1);
        chk("coll_data", 64'(bus.rd_data_o), 64'd10);
        rd_chk("coll_after", 3, 20'd50);
        idle();
        chk("hold_vld", 64'(bus.rd_data_val_o), 64'd0);
        chk("hold_data", 64'(bus.rd_data_o), 64'd50);

        // Different-flow packet and read in the same cycle.
        pkt(1, 5);
        step(1'b1, 4, 7, 1'b1, 1);
        chk("indep_vld", 64'(bus.rd_data_val_o), 64'd1);
        chk("indep_data", 64'(bus.rd_data_o), 64'd5);
        rd_chk("indep_flow4", 4, 20'd7);

        // Zero-size packet and disabled strobe leave the count alone.
        pkt(6, 9);
        pkt(6, 0);
        step(1'b0, 6, 1000, 1'b0, 0);
        rd_chk("zero_ignored", 6, 20'd9);

        // Wrap: 16 x 0xFFFF = 2**20 - 16, plus 0x20 -> 0x10.
        for (int i = 0; i < 16; i++) pkt(7, 16'hFFFF);
        pkt(7, 16'h20);
        rd_chk("wrap", 7, 20'h10);

        // Eight back-to-back reads of 0,10,...,70.
        for (int i = 0; i < NF; i++) pkt(i, 10 * i);
        for (int i = 0; i < NF; i++) begin
            rd_chk($sformatf("b2b%0d", i), i, DW'(10 * i));
        end

        // Pending read at reset must not produce a pulse.
        pkt(5, 123);
        step(1'b0, 0, 0, 1'b1, 5);
        rst_n = 1'b0;
        step(1'b1, 5, 11, 1'b1, 5);
        chk("drop_vld", 64'(bus.rd_data_val_o), 64'd0);
        chk("drop_data", 64'(bus.rd_data_o), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NF; i++) model[i] = '0;

        // Random mix against a reference model, with a reset mid-stream.
        for (int it = 0; it < 1000; it++) begin
            pe = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            pf = int'($urandom_range(0, NF - 1));
            rf = int'($urandom_range(0, NF - 1));
            ps = int'($urandom_range(0, 65535));
            if (it == 500) begin
                rst_n = 1'b0;
                step(pe, pf, ps, 1'b1, rf);
                chk("mid_rst_vld", 64'(bus.rd_data_val_o), 64'd0);
                chk("mid_rst_data", 64'(bus.rd_data_o), 64'd0);
                rst_n = 1'b1;
                for (int i = 0; i < NF; i++) model[i] = '0;
            end else begin
                exp_rd = model[rf];
                if (rs) model[rf] = '0;
                if (pe) model[pf] = model[pf] + DW'(ps);
                step(pe, pf, ps, rs, rf);
                chk($sformatf("rnd%0d_vld", it), 64'(bus.rd_data_val_o), 64'(rs));
                if (rs) chk($sformatf("rnd%0d_data", it), 64'(bus.rd_data_o), 64'(exp_rd));
            end
        end

        // Drain: every flow must match the model.
        for (int i = 0; i < NF; i++) begin
            rd_chk($sformatf("final%0d", i), i, model[i]);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
